tlb_op_unit: RTL and testbench
==============================

// Module: tlb_op_unit
// PURPOSE
// Executes the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR against the TLB array.
// Drives the array's search, read and write ports from CP0 state latched at accept time.
// Returns probe and read results to CP0, and owns the CP0 Random register.
// Sits between the WB-stage CP0 and the TLB.
// PARAMETERS
// TLBNUM  16  TLB entries; power of 2, 2..32. Localparam IW = $clog2(TLBNUM).
// PORTS
// clk            in   1     clock
// reset          in   1     reset, synchronous, active-high
// op_valid       in   1     TLB instruction request
// op_code        in   2     00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
// op_ready       out  1     request accepted on op_valid & op_ready
// done           out  1     one-cycle completion pulse
// c0_vpn2        in   19    EntryHi.VPN2
// c0_asid        in   8     EntryHi.ASID
// c0_mask        in   12    PageMask
// c0_lo0,c0_lo1  in   26    EntryLo0/1 packed {pfn[19:0],c[2:0],d,v,g}
// c0_index       in   IW    Index.index
// c0_wired       in   IW    Wired
// wired_we       in   1     CP0 write to Wired this cycle
// random         out  IW    Random register
// s_vpn2,s_odd_page,s_asid   out 19/1/8     TLB search request
// s_found,s_index            in  1/IW       TLB search result
// r_index                    out IW         TLB read index
// r_mask,r_vpn2,r_asid,r_g,r_{pfn,c,d,v}{0,1}  in   TLB read data (same widths as w_*)
// we,w_index                 out 1/IW       TLB write enable / index
// w_mask,w_vpn2,w_asid,w_g,w_{pfn,c,d,v}{0,1}  out  12/19/8/1/20/3/1/1 TLB write data
// probe_we,probe_p,probe_index  out 1/1/IW  Index update: valid / P (1 = miss) / match index
// rd_we,rd_vpn2,rd_asid,rd_mask,rd_lo0,rd_lo1  out 1/19/8/12/26/26  TLBR result to CP0
// BEHAVIOUR
// - FSM IDLE -> EXEC -> DONE -> IDLE; op_ready = (state == IDLE).
//   Accept at cycle T; EXEC at T+1; done = 1 at T+2; next accept at T+3 at the earliest.
// - Accept latches op_code and all c0_* inputs, plus the target index:
//   c0_index for TLBWI/TLBR, current random for TLBWR.
// - EXEC, TLBP: s_vpn2 and s_asid come from the latches; s_odd_page = 0.
//   Register s_found/s_index: probe_p = ~s_found; probe_index = s_found ? s_index : 0.
// - EXEC, TLBR: r_index = target. Register r_* into rd_*; rd_lo0.g = rd_lo1.g = r_g.
// - EXEC, TLBWI/TLBWR: we = 1 for exactly this cycle; w_index = target.
//   w_g = lo0.g & lo1.g; other w_* come straight from the latches; PageMask masking is done in the TLB.
// - we = 0 outside EXEC. s_*, r_index and w_* hold latched values; do not care.
// - DONE: done = 1; probe_we = done & TLBP; rd_we = done & TLBR.
//   probe_* and rd_* hold until the next EXEC of the same kind.
// - op_valid while busy is ignored; the requester holds it until accepted.
// - Random update, each cycle:
//   wired_we -> TLBNUM-1; else random <= c0_wired -> TLBNUM-1; else random - 1.
//   Random therefore cycles TLBNUM-1 down to wired; wired >= TLBNUM-1 pins it at TLBNUM-1.
// - TLBP with multiple matches: result is whatever the TLB returns; software forbids duplicates.
// - Reset, including in EXEC or DONE: state = IDLE, random = TLBNUM-1.
//   done, we, probe_we, rd_we = 0; probe_*, rd_* and the latches = 0.
//   An aborted write never asserts we; an aborted op never pulses done.
// - A write at EXEC T+1 is visible to an op accepted at T+3; no bypass is needed.
// TESTING
// 1. TLBWI, c0_index=5, vpn2=0x12345, asid=3, lo0={pfn 0x00100,c 3,d 1,v 1,g 1}, lo1.g=0
//    -> we high only at T+1, w_index=5, w_g=0; done at T+2; no probe_we, no rd_we.
// 2. TLBP vpn2=0x12345 asid=3 -> probe_p=0, probe_index=5; TLBP asid=4 -> probe_p=1, probe_index=0.
// 3. TLBR c0_index=5 -> at done: rd_vpn2=0x12345, rd_asid=3, rd_lo0.pfn=0x00100, rd_lo0.g=0.
// 4. Random: wired=0 -> 15,14..0,15. wired=12 -> 15,14,13,12,15.
//    wired_we at random=13 -> 15 next cycle. wired=15 -> constant 15.
// 5. TLBWR accepted with random=9 -> w_index=9 while random already reads 8 during EXEC.
// 6. Reset asserted in EXEC of TLBWI -> no we, no done; op_ready=1 after reset.
//    op_valid held high while busy is accepted only at T+3.

Source files
------------

// File: rtl/tlb_op_unit.sv
// Sequences CP0 TLBP/TLBR/TLBWI/TLBWR against the TLB array and owns the CP0 Random register.
// Accept -> EXEC -> DONE: one op every 3 cycles at most; busy requests wait (op_ready low).
module tlb_op_unit #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          done,
  input  logic [18:0]   c0_vpn2,
  input  logic [7:0]    c0_asid,
  input  logic [11:0]   c0_mask,
  input  logic [25:0]   c0_lo0,
  input  logic [25:0]   c0_lo1,
  input  logic [IW-1:0] c0_index,
  input  logic [IW-1:0] c0_wired,
  input  logic          wired_we,
  output logic [IW-1:0] random,
  output logic [18:0]   s_vpn2,
  output logic          s_odd_page,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  output logic [IW-1:0] r_index,
  input  logic [11:0]   r_mask,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1,
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [11:0]   w_mask,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1,
  output logic          probe_we,
  output logic          probe_p,
  output logic [IW-1:0] probe_index,
  output logic          rd_we,
  output logic [18:0]   rd_vpn2,
  output logic [7:0]    rd_asid,
  output logic [11:0]   rd_mask,
  output logic [25:0]   rd_lo0,
  output logic [25:0]   rd_lo1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);

  logic [1:0]    state;
  logic [1:0]    op_l;
  logic [18:0]   vpn2_l;
  logic [7:0]    asid_l;
  logic [11:0]   mask_l;
  logic [25:0]   lo0_l;
  logic [25:0]   lo1_l;
  logic [IW-1:0] tgt_l;

  assign op_ready = (state == IDLE);

  // Gated by reset so an op aborted mid-flight never writes or completes.
  assign we       = (state == EXEC) & op_l[1] & ~reset;
  assign done     = (state == DONE) & ~reset;
  assign probe_we = done & (op_l == OP_TLBP);
  assign rd_we    = done & (op_l == OP_TLBR);

  assign s_vpn2     = vpn2_l;
  assign s_asid     = asid_l;
  assign s_odd_page = 1'b0;
  assign r_index    = tgt_l;

  assign w_index = tgt_l;
  assign w_mask  = mask_l;
  assign w_vpn2  = vpn2_l;
  assign w_asid  = asid_l;
  assign w_g     = lo0_l[0] & lo1_l[0];
  assign w_pfn0  = lo0_l[25:6];
  assign w_c0    = lo0_l[5:3];
  assign w_d0    = lo0_l[2];
  assign w_v0    = lo0_l[1];
  assign w_pfn1  = lo1_l[25:6];
  assign w_c1    = lo1_l[5:3];
  assign w_d1    = lo1_l[2];
  assign w_v1    = lo1_l[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_l   <= '0;
      vpn2_l <= '0;
      asid_l <= '0;
      mask_l <= '0;
      lo0_l  <= '0;
      lo1_l  <= '0;
      tgt_l  <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          state  <= EXEC;
          op_l   <= op_code;
          vpn2_l <= c0_vpn2;
          asid_l <= c0_asid;
          mask_l <= c0_mask;
          lo0_l  <= c0_lo0;
          lo1_l  <= c0_lo1;
          tgt_l  <= (op_code == OP_TLBWR) ? random : c0_index;
        end
        EXEC:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Probe and read results are captured at the end of EXEC and held until the next op of their kind.
  always_ff @(posedge clk) begin
    if (reset) begin
      probe_p     <= 1'b0;
      probe_index <= '0;
      rd_vpn2     <= '0;
      rd_asid     <= '0;
      rd_mask     <= '0;
      rd_lo0      <= '0;
      rd_lo1      <= '0;
    end else if (state == EXEC) begin
      if (op_l == OP_TLBP) begin
        probe_p     <= ~s_found;
        probe_index <= s_found ? s_index : '0;
      end
      if (op_l == OP_TLBR) begin
        rd_vpn2 <= r_vpn2;
        rd_asid <= r_asid;
        rd_mask <= r_mask;
        rd_lo0  <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
        rd_lo1  <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || wired_we || random == c0_wired)
      random <= RAND_TOP;
    else
      random <= random - 1'b1;
  end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Bench for tlb_op_unit: behavioural TLB array, scoreboard of expected write/probe/read results.
module tb_tlb_op_unit;

  logic        clk, reset;
  logic        op_valid, op_ready, done;
  logic [1:0]  op_code;
  logic [18:0] c0_vpn2;
  logic [7:0]  c0_asid;
  logic [11:0] c0_mask;
  logic [25:0] c0_lo0, c0_lo1;
  logic [3:0]  c0_index, c0_wired, random;
  logic        wired_we;
  logic [18:0] s_vpn2;
  logic        s_odd_page, s_found;
  logic [7:0]  s_asid;
  logic [3:0]  s_index, r_index;
  logic [11:0] r_mask;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g, r_d0, r_v0, r_d1, r_v1;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [3:0]  w_index;
  logic [11:0] w_mask;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        probe_we, probe_p, rd_we;
  logic [3:0]  probe_index;
  logic [18:0] rd_vpn2;
  logic [7:0]  rd_asid;
  logic [11:0] rd_mask;
  logic [25:0] rd_lo0, rd_lo1;

  tlb_op_unit #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .done(done), .c0_vpn2(c0_vpn2), .c0_asid(c0_asid), .c0_mask(c0_mask), .c0_lo0(c0_lo0),
    .c0_lo1(c0_lo1), .c0_index(c0_index), .c0_wired(c0_wired), .wired_we(wired_we),
    .random(random), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .r_index(r_index), .r_mask(r_mask), .r_vpn2(r_vpn2),
    .r_asid(r_asid), .r_g(r_g), .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1), .we(we), .w_index(w_index),
    .w_mask(w_mask), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g), .w_pfn0(w_pfn0),
    .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0), .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1),
    .w_v1(w_v1), .probe_we(probe_we), .probe_p(probe_p), .probe_index(probe_index),
    .rd_we(rd_we), .rd_vpn2(rd_vpn2), .rd_asid(rd_asid), .rd_mask(rd_mask),
    .rd_lo0(rd_lo0), .rd_lo1(rd_lo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TLB: exact VPN2 match, global or ASID match; miss returns a junk index.
  logic [18:0] t_vpn2 [16];
  logic [7:0]  t_asid [16];
  logic [11:0] t_mask [16];
  logic        t_g    [16];
  logic [24:0] t_e0   [16];
  logic [24:0] t_e1   [16];

  always @(posedge clk) begin
    if (reset && cyc < 4) begin
      for (int i = 0; i < 16; i++) begin
        t_vpn2[i] <= '0; t_asid[i] <= '0; t_mask[i] <= '0;
        t_g[i] <= 1'b0; t_e0[i] <= '0; t_e1[i] <= '0;
      end
    end else if (we) begin
      t_vpn2[w_index] <= w_vpn2; t_asid[w_index] <= w_asid; t_mask[w_index] <= w_mask;
      t_g[w_index]    <= w_g;
      t_e0[w_index]   <= {w_pfn0, w_c0, w_d0, w_v0};
      t_e1[w_index]   <= {w_pfn1, w_c1, w_d1, w_v1};
    end
  end

  always_comb begin
    s_found = 1'b0;
    s_index = 4'hA;
    for (int i = 0; i < 16; i++)
      if (t_vpn2[i] == s_vpn2 && (t_g[i] || t_asid[i] == s_asid)) begin
        s_found = 1'b1;
        s_index = 4'(i);
      end
  end

  assign r_vpn2 = t_vpn2[r_index];
  assign r_asid = t_asid[r_index];
  assign r_mask = t_mask[r_index];
  assign r_g    = t_g[r_index];
  assign {r_pfn0, r_c0, r_d0, r_v0} = t_e0[r_index];
  assign {r_pfn1, r_c1, r_d1, r_v1} = t_e1[r_index];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  typedef struct {
    bit          is_wr, is_p, is_r;
    int          we_cyc, done_cyc;
    logic [3:0]  w_index;
    logic        w_g;
    logic [18:0] w_vpn2;
    logic        probe_p;
    logic [3:0]  probe_index;
    logic [18:0] rd_vpn2;
    logic [7:0]  rd_asid;
    logic [25:0] rd_lo0, rd_lo1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: checks writes at EXEC and completions at DONE against the queue head.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].is_wr && cyc == sb[0].we_cyc) begin
      chk("we_at_exec", 64'(we), 64'd1);
      chk("w_index", 64'(w_index), 64'(sb[0].w_index));
      chk("w_g", 64'(w_g), 64'(sb[0].w_g));
      chk("w_vpn2", 64'(w_vpn2), 64'(sb[0].w_vpn2));
    end else if (we) begin
      chk("spurious_we", 64'(we), 64'd0);
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        chk("probe_we", 64'(probe_we), 64'(mon_e.is_p));
        chk("rd_we", 64'(rd_we), 64'(mon_e.is_r));
        if (mon_e.is_p) begin
          chk("probe_p", 64'(probe_p), 64'(mon_e.probe_p));
          chk("probe_index", 64'(probe_index), 64'(mon_e.probe_index));
        end
        if (mon_e.is_r) begin
          chk("rd_vpn2", 64'(rd_vpn2), 64'(mon_e.rd_vpn2));
          chk("rd_asid", 64'(rd_asid), 64'(mon_e.rd_asid));
          chk("rd_lo0", 64'(rd_lo0), 64'(mon_e.rd_lo0));
          chk("rd_lo1", 64'(rd_lo1), 64'(mon_e.rd_lo1));
        end
      end
    end else if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
      chk("missing_done", 64'(done), 64'd1);
      void'(sb.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge of the EXEC cycle.
  task automatic issue(input logic [1:0] code, input exp_t e);
    op_code  = code;
    op_valid = 1'b1;
    for (int k = 0; k < 20 && !op_ready; k++) @(negedge clk);
    if (!op_ready) begin
      chk("accept_timeout", 64'(op_ready), 64'd1);
    end else begin
      e.we_cyc   = cyc + 1;
      e.done_cyc = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic pulse_wired(input logic [3:0] wv);
    c0_wired = wv;
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
  endtask

  logic [3:0] w12_exp [6] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd15, 4'd14};
  exp_t e;
  int a1, a2;

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; wired_we = 1'b0;
    c0_vpn2 = '0; c0_asid = '0; c0_mask = '0; c0_lo0 = '0; c0_lo1 = '0;
    c0_index = '0; c0_wired = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_probe_p", 64'(probe_p), 64'd0);
    chk("rst_rd_vpn2", 64'(rd_vpn2), 64'd0);

    // TLBWI entry 5, lo0 global but lo1 not -> stored non-global
    c0_index = 4'd5; c0_vpn2 = 19'h12345; c0_asid = 8'd3; c0_mask = 12'h000;
    c0_lo0 = {20'h00100, 3'd3, 1'b1, 1'b1, 1'b1};
    c0_lo1 = {20'h00200, 3'd2, 1'b1, 1'b1, 1'b0};
    e = '{default: 0};
    e.is_wr = 1; e.w_index = 4'd5; e.w_g = 1'b0; e.w_vpn2 = 19'h12345;
    issue(2'b10, e);
    wait_idle();

    // TLBP hit, then miss on ASID
    e = '{default: 0};
    e.is_p = 1; e.probe_p = 1'b0; e.probe_index = 4'd5;
    issue(2'b00, e);
    wait_idle();
    c0_asid = 8'd4;
    e = '{default: 0};
    e.is_p = 1; e.probe_p = 1'b1; e.probe_index = 4'd0;
    issue(2'b00, e);
    wait_idle();

    // TLBR entry 5 with unrelated EntryHi in CP0
    c0_vpn2 = 19'h0; c0_asid = 8'd0; c0_index = 4'd5;
    e = '{default: 0};
    e.is_r = 1; e.rd_vpn2 = 19'h12345; e.rd_asid = 8'd3;
    e.rd_lo0 = {20'h00100, 3'd3, 1'b1, 1'b1, 1'b0};
    e.rd_lo1 = {20'h00200, 3'd2, 1'b1, 1'b1, 1'b0};
    issue(2'b01, e);
    wait_idle();

    // Random with wired = 0
    pulse_wired(4'd0);
    for (int i = 0; i < 17; i++) begin
      chk("random_w0", 64'(random), (i == 16) ? 64'd15 : 64'(15 - i));
      @(negedge clk);
    end
    // wired = 12
    pulse_wired(4'd12);
    for (int i = 0; i < 6; i++) begin
      chk("random_w12", 64'(random), 64'(w12_exp[i]));
      @(negedge clk);
    end
    // Wired write while random = 13
    pulse_wired(4'd12);
    repeat (2) @(negedge clk);
    chk("random_pre_we", 64'(random), 64'd13);
    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    chk("random_after_we", 64'(random), 64'd15);
    @(negedge clk);
    chk("random_after_we2", 64'(random), 64'd14);
    // wired = 15 pins Random
    pulse_wired(4'd15);
    for (int i = 0; i < 5; i++) begin
      chk("random_w15", 64'(random), 64'd15);
      @(negedge clk);
    end

    // TLBWR accepted with random = 9
    pulse_wired(4'd0);
    repeat (6) @(negedge clk);
    chk("random_at_wr", 64'(random), 64'd9);
    c0_vpn2 = 19'h0ABCD; c0_asid = 8'd9; c0_index = 4'd2;
    c0_lo0 = {20'h00300, 3'd2, 1'b0, 1'b1, 1'b1};
    c0_lo1 = {20'h00301, 3'd2, 1'b0, 1'b1, 1'b1};
    e = '{default: 0};
    e.is_wr = 1; e.w_index = 4'd9; e.w_g = 1'b1; e.w_vpn2 = 19'h0ABCD;
    issue(2'b11, e);
    chk("random_in_exec", 64'(random), 64'd8);
    wait_idle();
    // Global entry at 9 matches any ASID
    c0_asid = 8'd77;
    e = '{default: 0};
    e.is_p = 1; e.probe_p = 1'b0; e.probe_index = 4'd9;
    issue(2'b00, e);
    wait_idle();

    // op_valid held high across a busy op: second accept three cycles later
    c0_vpn2 = 19'h12345; c0_asid = 8'd3;
    e = '{default: 0};
    e.is_p = 1; e.probe_p = 1'b0; e.probe_index = 4'd5;
    op_code = 2'b00;
    op_valid = 1'b1;
    a1 = cyc + 1;
    e.we_cyc = a1; e.done_cyc = a1 + 1;
    sb.push_back(e);
    @(negedge clk);
    for (int k = 0; k < 10 && !op_ready; k++) @(negedge clk);
    a2 = cyc + 1;
    e.we_cyc = a2; e.done_cyc = a2 + 1;
    sb.push_back(e);
    chk("hold_accept_gap", 64'(a2 - a1), 64'd3);
    @(negedge clk);
    op_valid = 1'b0;
    wait_idle();

    // Reset during EXEC of a TLBWI aborts it
    c0_index = 4'd7; c0_vpn2 = 19'h7777;
    op_code = 2'b10;
    op_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("abort_we", 64'(we), 64'd0);
    chk("abort_done_exec", 64'(done), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_op_ready", 64'(op_ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_random", 64'(random), 64'd15);
    chk("abort_probe_index", 64'(probe_index), 64'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
